// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_pkg                                                 |
// | Purpose : Shared types, constants and address-split helpers for the  |
// |           direct-mapped write-through data-cache controller.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } size_t;

  localparam int LINE_BYTES  = 4;
  localparam int OFFSET_BITS = 2;

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int sets);
    return addr_width - OFFSET_BITS - $clog2(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_mem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_cpu_if / dcache_mem_if                              |
// | Purpose : CPU load/store bus and byte-wide memory bus of the cache.  |
// |   dcache_cpu_if : req, we, size, addr, wdata (CPU -> cache)          |
// |                   rdata, ready                (cache -> CPU)         |
// |   dcache_mem_if : we, a, wd (cache -> memory), rd (memory -> cache)  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface dcache_cpu_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic                     we;
  logic                     size;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     ready;

  modport master (output req, we, size, addr, wdata, input rdata, ready);
  modport slave  (input req, we, size, addr, wdata, output rdata, ready);
endinterface

interface dcache_mem_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MEM_DATA_WIDTH = 8
);
  logic                      we;
  logic [ADDRESS_WIDTH-1:0]  a;
  logic [MEM_DATA_WIDTH-1:0] wd;
  logic [MEM_DATA_WIDTH-1:0] rd;

  modport master (output we, a, wd, input rd);
  modport slave  (input we, a, wd, output rd);
endinterface
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_line_store                                          |
// | Purpose : Valid/tag/data arrays with combinational lookup and a      |
// |           single per-byte write port. Only valid bits are reset.     |
// | Ports   : clk, rst        clock, async active-high reset             |
// |           idx, tag        lookup / write line select and tag         |
// |           hit, line_data  lookup result                              |
// |           wr_en, wr_sel, wr_byte  byte write into line idx           |
// |           fill_done       mark line idx valid with tag               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dcache_line_store #(
  parameter int SETS  = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 27
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [IDX_W-1:0] idx,
  input  wire logic [TAG_W-1:0] tag,
  output logic                  hit,
  output logic [31:0]           line_data,
  input  wire logic             wr_en,
  input  wire logic [1:0]       wr_sel,
  input  wire logic [7:0]       wr_byte,
  input  wire logic             fill_done
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (fill_done) begin
      r_valid[idx] <= 1'b1;
    end
  end

  // Tag and data are deliberately left unreset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[idx][{wr_sel, 3'b000} +: 8] <= wr_byte;
    end
    if (fill_done) begin
      r_tag[idx] <= tag;
    end
  end

  assign hit       = r_valid[idx] && (r_tag[idx] == tag);
  assign line_data = r_data[idx];

endmodule
`default_nettype wire

// File: rtl/dcache_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_mem_ctrl                                            |
// | Purpose : Direct-mapped, write-through, no-write-allocate data cache |
// |           controller. Refills and word stores are split into four    |
// |           little-endian byte transactions on the memory port.        |
// | Ports   : clk, rst  clock, async active-high reset                   |
// |           cpu       CPU load/store bus (slave side)                  |
// |           mem       byte-wide memory bus (master side)               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dcache_mem_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int SETS           = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  dcache_cpu_if.slave cpu,
  dcache_mem_if.master mem
);

  localparam int         IDX_W = index_bits(SETS);
  localparam int         TAG_W = tag_bits(ADDRESS_WIDTH, SETS);
  localparam logic [1:0] C_LAST = 2'(LINE_BYTES - 1);

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_st_hit;   // store hit, frozen at IDLE->WRITE
  logic       r_st_word;

  logic [IDX_W-1:0]          w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [1:0]                w_off;
  logic                      w_hit;
  logic [DATA_WIDTH-1:0]     w_line_data;
  logic [MEM_DATA_WIDTH-1:0] w_wbyte;
  logic [MEM_DATA_WIDTH-1:0] w_lbyte;
  logic                      w_wr_en;
  logic [MEM_DATA_WIDTH-1:0] w_wr_byte;
  logic                      w_fill_done;
  logic [ADDRESS_WIDTH-1:0]  w_byte_addr;

  assign w_idx       = cpu.addr[OFFSET_BITS +: IDX_W];
  assign w_tag       = cpu.addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign w_off       = cpu.addr[1:0];
  assign w_byte_addr = {cpu.addr[ADDRESS_WIDTH-1:2], r_cnt};
  assign w_wbyte     = r_st_word ? cpu.wdata[{r_cnt, 3'b000} +: 8] : cpu.wdata[7:0];
  assign w_lbyte     = w_line_data[{w_off, 3'b000} +: 8];

  dcache_line_store #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .idx       (w_idx),
    .tag       (w_tag),
    .hit       (w_hit),
    .line_data (w_line_data),
    .wr_en     (w_wr_en),
    .wr_sel    (r_cnt),
    .wr_byte   (w_wr_byte),
    .fill_done (w_fill_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_st_hit  <= 1'b0;
      r_st_word <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu.req) begin
            if (cpu.we) begin
              r_state   <= WRITE;
              r_cnt     <= (cpu.size == SZ_WORD) ? 2'd0 : w_off;
              r_st_hit  <= w_hit;
              r_st_word <= (cpu.size == SZ_WORD);
            end else if (!w_hit) begin
              r_state <= REFILL;
              r_cnt   <= 2'd0;
            end
          end
        end
        REFILL: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == C_LAST) begin
            r_state <= IDLE;
          end
        end
        WRITE: begin
          if (!r_st_word || (r_cnt == C_LAST)) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; a load hit must answer in the
  // request cycle, so ready/rdata also depend on the live lookup.
  always_comb begin
    cpu.ready   = 1'b0;
    cpu.rdata   = '0;
    mem.we      = 1'b0;
    mem.a       = '0;
    mem.wd      = '0;
    w_wr_en     = 1'b0;
    w_wr_byte   = '0;
    w_fill_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu.req && !cpu.we && w_hit) begin
          cpu.ready = 1'b1;
          cpu.rdata = (cpu.size == SZ_WORD) ? w_line_data
                    : {{(DATA_WIDTH-MEM_DATA_WIDTH){1'b0}}, w_lbyte};
        end
      end
      REFILL: begin
        mem.a       = w_byte_addr;
        w_wr_en     = 1'b1;
        w_wr_byte   = mem.rd;
        w_fill_done = (r_cnt == C_LAST);
      end
      WRITE: begin
        mem.we    = 1'b1;
        mem.a     = w_byte_addr;
        mem.wd    = w_wbyte;
        w_wr_en   = r_st_hit;
        w_wr_byte = w_wbyte;
        cpu.ready = cpu.req && (!r_st_word || (r_cnt == C_LAST));
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dcache_mem_ctrl                                         |
// | Purpose : Self-checking bench for dcache_mem_ctrl with a byte memory |
// |           model and scoreboard queues for CPU and memory traffic.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_dcache_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_cpu_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32))    cpu_bus ();
  dcache_mem_if #(.ADDRESS_WIDTH(32), .MEM_DATA_WIDTH(8)) mem_bus ();

  dcache_mem_ctrl #(
    .ADDRESS_WIDTH  (32),
    .DATA_WIDTH     (32),
    .MEM_DATA_WIDTH (8),
    .SETS           (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_bus),
    .mem (mem_bus)
  );

  // Byte memory model: low 10 address bits are enough for the addresses used.
  logic [7:0] mem_arr [0:1023];
  logic       pre_we;
  logic [9:0] pre_a;
  logic [7:0] pre_d;

  always @(posedge clk) begin
    if (pre_we)           mem_arr[pre_a] <= pre_d;
    else if (mem_bus.we)  mem_arr[mem_bus.a[9:0]] <= mem_bus.wd;
  end
  assign mem_bus.rd = mem_arr[mem_bus.a[9:0]];

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] exp_rdata_q [$];
  int          exp_lat_q   [$];
  logic [31:0] exp_rd_q    [$];
  logic [39:0] exp_wr_q    [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: every write and every non-zero read address must
  // match the next expected transaction.
  always @(negedge clk) begin : mon
    logic [39:0] e;
    if (!rst) begin
      if (mem_bus.we) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_unexp", {31'b0, mem_bus.we}, 32'd0);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", mem_bus.a, e[39:8]);
          check("wr_data", {24'b0, mem_bus.wd}, {24'b0, e[7:0]});
        end
      end else if (mem_bus.a != 32'd0) begin
        if (exp_rd_q.size() == 0) check("rd_unexp", mem_bus.a, 32'd0);
        else                      check("rd_addr", mem_bus.a, exp_rd_q.pop_front());
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      pre_a  = a + 10'(i);
      pre_d  = w[8*i +: 8];
      pre_we = 1'b1;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
  endtask

  task automatic access(input logic we, input logic sz, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input int exp_lat, input bit chk_data);
    int   cycles;
    bit   got;
    logic [31:0] er;
    int   el;
    exp_rdata_q.push_back(exp_rdata);
    exp_lat_q.push_back(exp_lat);
    if (!we && exp_lat > 0)
      for (int i = 0; i < 4; i++) exp_rd_q.push_back({addr[31:2], 2'(i)});
    if (we) begin
      if (sz) for (int i = 0; i < 4; i++) exp_wr_q.push_back({addr[31:2], 2'(i), wdata[8*i +: 8]});
      else    exp_wr_q.push_back({addr, wdata[7:0]});
    end
    @(posedge clk); #1;
    cpu_bus.req = 1'b1; cpu_bus.we = we; cpu_bus.size = sz;
    cpu_bus.addr = addr; cpu_bus.wdata = wdata;
    cycles = 0; got = 0;
    while (!got && cycles <= 20) begin
      @(negedge clk);
      if (cpu_bus.ready) got = 1;
      else begin
        check("rdata_stall", cpu_bus.rdata, 32'd0);
        cycles++;
      end
    end
    er = exp_rdata_q.pop_front();
    el = exp_lat_q.pop_front();
    if (!got) begin
      check("ready_timeout", {31'b0, cpu_bus.ready}, 32'd1);
    end else begin
      check("latency", cycles, el);
      if (chk_data) check("rdata", cpu_bus.rdata, er);
    end
    @(posedge clk); #1;
    cpu_bus.req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.size = 1'b0;
    cpu_bus.addr = '0; cpu_bus.wdata = '0;
    @(posedge clk); #1;
    preload(10'h000, 32'h4433_2211);
    preload(10'h020, 32'hD4C3_B2A1);
    preload(10'h010, 32'h8877_6655);
    @(negedge clk);
    check("rst_ready", {31'b0, cpu_bus.ready}, 32'd0);
    check("rst_rdata", cpu_bus.rdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_bus.we}, 32'd0);
    check("rst_mem_a", mem_bus.a, 32'd0);
    check("rst_mem_wd", {24'b0, mem_bus.wd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Refill then hit
    access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h4433_2211, 5, 1);
    access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h4433_2211, 0, 1);
    access(1'b0, 1'b0, 32'h0001_0003, 32'h0, 32'h0000_0044, 0, 1);
    // Byte store hit, write-through
    access(1'b1, 1'b0, 32'h0001_0002, 32'h0000_00AB, 32'h0, 1, 0);
    access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h44AB_2211, 0, 1);
    // Word store miss leaves the cached line alone
    access(1'b1, 1'b1, 32'h0001_0100, 32'hDEAD_BEEF, 32'h0, 4, 0);
    access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h44AB_2211, 0, 1);
    access(1'b0, 1'b1, 32'h0001_0100, 32'h0, 32'hDEAD_BEEF, 5, 1);
    // Conflicting tags on the same index
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) access(1'b0, 1'b1, 32'h0001_0020, 32'h0, 32'hD4C3_B2A1, 5, 1);
      else            access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h44AB_2211, 5, 1);
    end
    access(1'b0, 1'b0, 32'h0001_0003, 32'h0, 32'h0000_0044, 0, 1);
    access(1'b0, 1'b0, 32'h0001_0001, 32'h0, 32'h0000_0022, 0, 1);
    // Word store hit
    access(1'b1, 1'b1, 32'h0001_0000, 32'h0102_0304, 32'h0, 4, 0);
    access(1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h0102_0304, 0, 1);

    // Reset in the second refill cycle
    exp_rd_q.push_back(32'h0001_0010);
    exp_rd_q.push_back(32'h0001_0011);
    @(posedge clk); #1;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.size = 1'b1;
    cpu_bus.addr = 32'h0001_0010;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_ready", {31'b0, cpu_bus.ready}, 32'd0);
    check("arst_rdata", cpu_bus.rdata, 32'd0);
    check("arst_mem_we", {31'b0, mem_bus.we}, 32'd0);
    check("arst_mem_a", mem_bus.a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_bus.req = 1'b0;
    access(1'b0, 1'b1, 32'h0001_0010, 32'h0, 32'h8877_6655, 5, 1);

    repeat (2) @(posedge clk);
    check("rd_q_left", exp_rd_q.size(), 32'd0);
    check("wr_q_left", exp_wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data-cache controller between the CPU load/store path and the byte-wide data memory.
- It is the initiator on the memory port. It issues byte addresses, reads combinationally returned bytes, and drives single-cycle synchronous byte writes.
- Word refills and word stores are serialised into four little-endian byte transactions.
- The CPU sees a valid/ready stall handshake.

Parameters:
- ADDRESS_WIDTH, 32, width of CPU and memory byte addresses.
- DATA_WIDTH, 32, CPU word width. Fixed at 4 bytes.
- MEM_DATA_WIDTH, 8, memory data port width.
- SETS, 8, number of one-word lines. Must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held stable until ready is sampled high.
- cpu_we  in  1  1=store, 0=load.
- cpu_size  in  1  0=byte, 1=word (addr[1:0] ignored for word).
- cpu_addr  in  ADDRESS_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data; byte stores use [7:0].
- cpu_rdata  out  DATA_WIDTH  load data; byte loads zero-extended; 0 when cpu_ready=0.
- cpu_ready  out  1  access completes this cycle.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDRESS_WIDTH  memory byte address.
- mem_wd  out  MEM_DATA_WIDTH  memory write byte.
- mem_rd  in  MEM_DATA_WIDTH  memory read byte, valid combinationally for mem_a.

Behaviour:
- Address split:
  - offset = addr[1:0]
  - index = addr[2+log2(SETS)-1:2]
  - tag = remaining upper bits
  - Each line holds valid, tag and 32-bit data (byte k at bits 8k+7:8k).
- Reset (async, any state):
  - All valid bits 0, FSM=IDLE, byte counter=0.
  - cpu_ready=0, cpu_rdata=0, mem_we=0, mem_a=0, mem_wd=0.
  - Line data/tag are not cleared.
- States: IDLE, REFILL, WRITE.
- IDLE:
  - mem_we=0, mem_a=0.
  - Load hit (req, !we, valid, tag match): cpu_ready=1 in the same cycle; cpu_rdata = word or selected byte. No state change.
  - Load miss: go to REFILL, cnt=0. cpu_ready=0.
  - Store (hit or miss): go to WRITE, cnt=0 for word, cnt=offset for byte. cpu_ready=0.
- REFILL:
  - mem_a = {addr[31:2], cnt}, mem_we=0.
  - On the clock edge, capture mem_rd into line byte cnt, then cnt++.
  - On the edge where cnt==3: set valid=1, write the tag, return to IDLE.
  - The held request then hits, so a miss completes 5 cycles after the request first appears.
  - cpu_ready=0 throughout.
- WRITE:
  - mem_we=1, mem_a={addr[31:2],cnt}, mem_wd=cpu_wdata byte (cnt for word, [7:0] for byte).
  - If the line is a hit, update the same line byte on the same edge (write-through). On a miss the line is untouched.
  - Byte store: one cycle, cpu_ready=1 in that cycle, then IDLE.
  - Word store: cnt 0..3 over 4 cycles, cpu_ready=1 only in the cnt==3 cycle, then IDLE.
- Hit/miss for stores is evaluated once on IDLE→WRITE and latched; it is not re-evaluated per byte.
- Reset during REFILL discards the partial line (valid stays 0).
- Reset during a word WRITE may leave memory partially written. This is legal; the CPU re-issues the store after reset.
- If cpu_req drops while in REFILL or WRITE, the sequence completes anyway; cpu_ready is gated by cpu_req and stays 0.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, REFILL, WRITE}
  - size enum {SZ_BYTE, SZ_WORD}
  - LINE_BYTES=4
  - index/tag width functions from SETS
- Sub-module dcache_line_store: valid/tag/data arrays, combinational lookup (hit, rdata) and per-byte write port with async valid clear.

Test Plan:
1. Memory 0x10000..0x10003 = 11,22,33,44; word load 0x10000 after reset → mem_a 0x10000..0x10003 on cycles 1-4, cpu_ready on cycle 5, rdata 0x44332211. Repeat the load → cpu_ready same cycle, mem_a stays 0.
2. With that line cached, byte store 0x10002=0xAB → one cycle mem_we=1, mem_a=0x10002, mem_wd=0xAB, cpu_ready=1. Next word load of 0x10000 hits, rdata 0x44AB2211.
3. Word store miss 0x10100=0xDEADBEEF → mem_wd EF,BE,AD,DE at 0x10100..0x10103, ready on the 4th cycle. Following load of 0x10100 misses, refills, returns 0xDEADBEEF.
4. SETS=8, alternate loads 0x10000 and 0x10020 (same index, different tag) → every access misses with 4 refill cycles, and the correct data is returned each time.
5. Assert rst during the 2nd REFILL cycle → outputs immediately 0, state IDLE. Re-issued load performs a full 4-byte refill.
6. Byte load 0x10003 with the line cached → cpu_rdata 0x00000044 in the same cycle.
